// File: rtl/alu_exec_stage_pkg.sv
// Shared constants for the execute stage: ALU select codes, ALUOp and funct encodings.
package alu_exec_stage_pkg;

   // ALU select (S) encodings understood by the ALU
   localparam logic [2:0] ALU_AND = 3'b000;
   localparam logic [2:0] ALU_OR  = 3'b001;
   localparam logic [2:0] ALU_ADD = 3'b010;
   localparam logic [2:0] ALU_SUB = 3'b110;
   localparam logic [2:0] ALU_SLT = 3'b111;

   // ALUOp codes from the decoder
   localparam logic [1:0] OP_ADD   = 2'b00;
   localparam logic [1:0] OP_SUB   = 2'b01;
   localparam logic [1:0] OP_RTYPE = 2'b10;

   // R-type funct codes
   localparam logic [5:0] FN_ADD = 6'b100000;
   localparam logic [5:0] FN_SUB = 6'b100010;
   localparam logic [5:0] FN_AND = 6'b100100;
   localparam logic [5:0] FN_OR  = 6'b100101;
   localparam logic [5:0] FN_SLT = 6'b101010;

endpackage

// File: rtl/alu_exec_stage_alu.sv
// Combinational ALU (A, B, S -> O, Zero) with [0:DATA_W-1] bit order.
module alu
   import alu_exec_stage_pkg::*;
#(
   parameter int DATA_W = 32
) (
   input  logic [0:DATA_W-1] a,
   input  logic [0:DATA_W-1] b,
   input  logic [2:0]        s,
   output logic [0:DATA_W-1] o,
   output logic              zero
);

   // Operation select; add/sub wrap at DATA_W, slt compares as signed
   always_comb begin
      o = {DATA_W{1'b0}};
      case (s)
         ALU_AND: o = a & b;
         ALU_OR:  o = a | b;
         ALU_ADD: o = a + b;
         ALU_SUB: o = a - b;
         ALU_SLT: o = ($signed(a) < $signed(b)) ? {{(DATA_W-1){1'b0}}, 1'b1}
                                                : {DATA_W{1'b0}};
         default: o = {DATA_W{1'b0}};
      endcase
   end

   assign zero = (o == {DATA_W{1'b0}});

endmodule

// File: rtl/alu_exec_stage_ctrl.sv
// ALU control: maps alu_op/funct to the 3-bit ALU select and flags undecodable ops.
module alu_ctrl
   import alu_exec_stage_pkg::*;
(
   input  logic [1:0] alu_op,
   input  logic [5:0] funct,
   output logic [2:0] sel,
   output logic       illegal
);

   // Decode; unknown encodings fall back to add so the op still produces A+B
   always_comb begin
      sel     = ALU_ADD;
      illegal = 1'b0;
      case (alu_op)
         OP_ADD: sel = ALU_ADD;
         OP_SUB: sel = ALU_SUB;
         OP_RTYPE: begin
            case (funct)
               FN_ADD:  sel = ALU_ADD;
               FN_SUB:  sel = ALU_SUB;
               FN_AND:  sel = ALU_AND;
               FN_OR:   sel = ALU_OR;
               FN_SLT:  sel = ALU_SLT;
               default: begin
                  sel     = ALU_ADD;
                  illegal = 1'b1;
               end
            endcase
         end
         default: begin
            sel     = ALU_ADD;
            illegal = 1'b1;
         end
      endcase
   end

endmodule

// File: rtl/alu_exec_stage.sv
// Two-stage execute pipeline: ID/EX operand register, ALU, EX/MEM result register,
// valid/ready on both sides, flush kills everything in flight.
module alu_exec_stage
   import alu_exec_stage_pkg::*;
#(
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [1:0]        alu_op,
   input  logic [5:0]        funct,
   input  logic [0:DATA_W-1] rs_val,
   input  logic [0:DATA_W-1] rt_val,
   input  logic [0:DATA_W-1] imm,
   input  logic              alu_src,
   input  logic              flush,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [0:DATA_W-1] result,
   output logic              zero,
   output logic              illegal
);

   logic [2:0]        sel_s;
   logic              ill_dec_s;
   logic [0:DATA_W-1] b_mux_s;
   logic [0:DATA_W-1] alu_o_s;
   logic              alu_zero_s;
   logic              adv1_s;
   logic              adv2_s;

   logic [0:DATA_W-1] a_r;
   logic [0:DATA_W-1] b_r;
   logic [2:0]        sel_r;
   logic              ill1_r;
   logic              v1_r;
   logic [0:DATA_W-1] result_r;
   logic              zero_r;
   logic              ill2_r;
   logic              v2_r;

   alu_ctrl u_ctrl (
      .alu_op  (alu_op),
      .funct   (funct),
      .sel     (sel_s),
      .illegal (ill_dec_s)
   );

   assign b_mux_s = alu_src ? imm : rt_val;

   // A stage advances when it is empty or its successor advances
   assign adv2_s   = !v2_r || out_ready;
   assign adv1_s   = !v1_r || adv2_s;
   assign in_ready = adv1_s;

   // ID/EX register: capture decoded operands on accept; flush empties the stage
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         v1_r   <= 1'b0;
         a_r    <= {DATA_W{1'b0}};
         b_r    <= {DATA_W{1'b0}};
         sel_r  <= ALU_ADD;
         ill1_r <= 1'b0;
      end else if (flush) begin
         v1_r <= 1'b0;
      end else if (adv1_s) begin
         v1_r <= in_valid;
         if (in_valid) begin
            a_r    <= rs_val;
            b_r    <= b_mux_s;
            sel_r  <= sel_s;
            ill1_r <= ill_dec_s;
         end
      end
   end

   alu #(.DATA_W(DATA_W)) u_alu (
      .a    (a_r),
      .b    (b_r),
      .s    (sel_r),
      .o    (alu_o_s),
      .zero (alu_zero_s)
   );

   // EX/MEM register: holds its result while downstream stalls
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         v2_r     <= 1'b0;
         result_r <= {DATA_W{1'b0}};
         zero_r   <= 1'b0;
         ill2_r   <= 1'b0;
      end else if (flush) begin
         v2_r <= 1'b0;
      end else if (adv2_s) begin
         v2_r <= v1_r;
         if (v1_r) begin
            result_r <= alu_o_s;
            zero_r   <= alu_zero_s;
            ill2_r   <= ill1_r;
         end
      end
   end

   assign out_valid = v2_r;
   assign result    = result_r;
   assign zero      = zero_r;
   assign illegal   = ill2_r;

endmodule

// File: tb/tb_alu_exec_stage.sv
// Directed testbench for alu_exec_stage with hand-computed expectations.
module tb_alu_exec_stage;

   logic        clk;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [1:0]  alu_op;
   logic [5:0]  funct;
   logic [31:0] rs_val;
   logic [31:0] rt_val;
   logic [31:0] imm;
   logic        alu_src;
   logic        flush;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] result;
   logic        zero;
   logic        illegal;

   int checks;
   int errors;

   alu_exec_stage #(.DATA_W(32)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .alu_op    (alu_op),
      .funct     (funct),
      .rs_val    (rs_val),
      .rt_val    (rt_val),
      .imm       (imm),
      .alu_src   (alu_src),
      .flush     (flush),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .result    (result),
      .zero      (zero),
      .illegal   (illegal)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic [1:0] op, input logic [5:0] fn, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] im, input logic src);
      in_valid = 1'b1;
      alu_op   = op;
      funct    = fn;
      rs_val   = a;
      rt_val   = b;
      imm      = im;
      alu_src  = src;
   endtask

   // Issue one op, idle one cycle, then check the result two cycles after accept
   task automatic run_op(input string tag, input logic [1:0] op, input logic [5:0] fn,
                         input logic [31:0] a, input logic [31:0] b, input logic [31:0] im,
                         input logic src, input logic [31:0] exp_res, input logic exp_zero,
                         input logic exp_ill);
      drive(op, fn, a, b, im, src);
      tick();
      in_valid = 1'b0;
      check({tag, "_lat1_valid"}, {31'd0, out_valid}, 32'd0);
      tick();
      check({tag, "_valid"}, {31'd0, out_valid}, 32'd1);
      check({tag, "_result"}, result, exp_res);
      check({tag, "_zero"}, {31'd0, zero}, {31'd0, exp_zero});
      check({tag, "_illegal"}, {31'd0, illegal}, {31'd0, exp_ill});
      tick();
   endtask

   initial begin
      checks    = 0;
      errors    = 0;
      rst_n     = 1'b0;
      in_valid  = 1'b0;
      alu_op    = 2'b00;
      funct     = 6'b000000;
      rs_val    = 32'd0;
      rt_val    = 32'd0;
      imm       = 32'd0;
      alu_src   = 1'b0;
      flush     = 1'b0;
      out_ready = 1'b1;
      #12;
      check("rst_out_valid", {31'd0, out_valid}, 32'd0);
      check("rst_result", result, 32'd0);
      check("rst_zero", {31'd0, zero}, 32'd0);
      check("rst_illegal", {31'd0, illegal}, 32'd0);
      rst_n = 1'b1;
      tick();
      check("rst_in_ready", {31'd0, in_ready}, 32'd1);

      // Basic function
      run_op("add",    2'b10, 6'b100000, 32'd10, 32'd12, 32'd0, 1'b0, 32'd22, 1'b0, 1'b0);
      run_op("sub",    2'b01, 6'b000000, 32'd5,  32'd5,  32'd0, 1'b0, 32'd0,  1'b1, 1'b0);
      run_op("slt_lt", 2'b10, 6'b101010, 32'd10, 32'd11, 32'd0, 1'b0, 32'd1,  1'b0, 1'b0);
      run_op("slt_sg", 2'b10, 6'b101010, 32'hFFFF_FFFF, 32'd0, 32'd0, 1'b0, 32'd1, 1'b0, 1'b0);
      run_op("slt_ge", 2'b10, 6'b101010, 32'd11, 32'd10, 32'd0, 1'b0, 32'd0,  1'b1, 1'b0);
      run_op("and",    2'b10, 6'b100100, 32'd10, 32'd11, 32'd0, 1'b0, 32'd10, 1'b0, 1'b0);
      run_op("or",     2'b10, 6'b100101, 32'd10, 32'd11, 32'd0, 1'b0, 32'd11, 1'b0, 1'b0);
      run_op("rsub",   2'b10, 6'b100010, 32'd0,  32'd1,  32'd0, 1'b0, 32'hFFFF_FFFF, 1'b0, 1'b0);
      run_op("wrap",   2'b00, 6'b000000, 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b0, 32'd0, 1'b1, 1'b0);
      run_op("immsrc", 2'b00, 6'b000000, 32'd100, 32'd55, 32'hFFFF_FFFD, 1'b1, 32'd97, 1'b0, 1'b0);
      run_op("ill_fn", 2'b10, 6'b000000, 32'd3,  32'd4,  32'd0, 1'b0, 32'd7,  1'b0, 1'b1);
      run_op("ill_op", 2'b11, 6'b100100, 32'd1,  32'd2,  32'd0, 1'b0, 32'd3,  1'b0, 1'b1);

      // Five back-to-back ops: results in consecutive cycles
      for (int c = 0; c < 7; c++) begin
         if (c < 5) drive(2'b00, 6'b000000, 32'd100 + 32'(c), 32'd0, 32'd0, 1'b0);
         else in_valid = 1'b0;
         tick();
         if (c >= 1 && c <= 5) begin
            check("b2b_valid", {31'd0, out_valid}, 32'd1);
            check("b2b_result", result, 32'd99 + 32'(c));
         end
      end
      check("b2b_drained", {31'd0, out_valid}, 32'd0);

      // Backpressure: three ops with downstream stalled
      out_ready = 1'b0;
      drive(2'b00, 6'b000000, 32'd200, 32'd0, 32'd0, 1'b0);
      check("bp_ready_empty", {31'd0, in_ready}, 32'd1);
      tick();
      drive(2'b00, 6'b000000, 32'd201, 32'd0, 32'd0, 1'b0);
      check("bp_ready_v1only", {31'd0, in_ready}, 32'd1);
      tick();
      check("bp_ready_full", {31'd0, in_ready}, 32'd0);
      check("bp_valid0", {31'd0, out_valid}, 32'd1);
      check("bp_hold0", result, 32'd200);
      drive(2'b00, 6'b000000, 32'd202, 32'd0, 32'd0, 1'b0);
      tick();
      check("bp_ready_full2", {31'd0, in_ready}, 32'd0);
      check("bp_hold1", result, 32'd200);
      tick();
      check("bp_hold2", result, 32'd200);
      check("bp_valid2", {31'd0, out_valid}, 32'd1);
      out_ready = 1'b1;
      tick();
      in_valid = 1'b0;
      check("bp_res1_valid", {31'd0, out_valid}, 32'd1);
      check("bp_res1", result, 32'd201);
      tick();
      check("bp_res2_valid", {31'd0, out_valid}, 32'd1);
      check("bp_res2", result, 32'd202);
      tick();
      check("bp_no_dup", {31'd0, out_valid}, 32'd0);

      // Flush with both stages full plus a pending op
      out_ready = 1'b0;
      drive(2'b00, 6'b000000, 32'd300, 32'd0, 32'd0, 1'b0);
      tick();
      drive(2'b00, 6'b000000, 32'd301, 32'd0, 32'd0, 1'b0);
      tick();
      drive(2'b00, 6'b000000, 32'd302, 32'd0, 32'd0, 1'b0);
      flush = 1'b1;
      tick();
      flush    = 1'b0;
      in_valid = 1'b0;
      check("flush_valid", {31'd0, out_valid}, 32'd0);
      check("flush_ready", {31'd0, in_ready}, 32'd1);
      out_ready = 1'b1;
      tick();
      check("flush_empty", {31'd0, out_valid}, 32'd0);
      // Flush on an empty pipe discards the op presented in that cycle
      drive(2'b00, 6'b000000, 32'd303, 32'd0, 32'd0, 1'b0);
      flush = 1'b1;
      tick();
      flush    = 1'b0;
      in_valid = 1'b0;
      tick();
      check("flush_discard", {31'd0, out_valid}, 32'd0);
      run_op("post_flush", 2'b10, 6'b100000, 32'd7, 32'd8, 32'd0, 1'b0, 32'd15, 1'b0, 1'b0);

      // Reset mid-stream
      drive(2'b00, 6'b000000, 32'd400, 32'd0, 32'd0, 1'b0);
      tick();
      drive(2'b00, 6'b000000, 32'd401, 32'd0, 32'd0, 1'b0);
      tick();
      check("mid_valid_pre", {31'd0, out_valid}, 32'd1);
      rst_n = 1'b0;
      #1;
      check("mid_rst_valid", {31'd0, out_valid}, 32'd0);
      check("mid_rst_result", result, 32'd0);
      in_valid = 1'b0;
      tick();
      rst_n = 1'b1;
      tick();
      check("mid_after1", {31'd0, out_valid}, 32'd0);
      tick();
      check("mid_after2", {31'd0, out_valid}, 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
